ad5065_axil_slave: RTL

AD5065_AXIL_SLAVE -- requirements
Module: ad5065_axil_slave

---
 rtl/ad5065_axil_slave_if.sv | 40 ++++
 rtl/ad5065_axil_slave.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ad5065_axil_slave_if.sv
// AXI4-Lite slave bundle for the AD5065 serial DAC controller.
// Signal names follow the AXI register-slave port naming of the block.
interface ad5065_axil_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARVALID, output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, input S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARVALID, input S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
    );
endinterface

// File: rtl/ad5065_axil_slave.sv
// AXI4-Lite register slave that serialises a 32-bit FRAME word to an AD5065 DAC.
// Registers: FRAME, CLK_DIV, STATUS (BUSY, DROP W1C), SCRATCH.
module ad5065_axil_slave #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] CLK_DIV_RST        = 32'd4
) (
    input  logic               ACLK,
    input  logic               ARESET,
    ad5065_axil_slave_if.slave s_axi,
    output logic               DAC_SYNC_N,
    output logic               DAC_SCLK,
    output logic               DAC_DIN
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    localparam logic [1:0] A_FRAME   = 2'd0;
    localparam logic [1:0] A_CLK_DIV = 2'd1;
    localparam logic [1:0] A_STATUS  = 2'd2;
    localparam logic [1:0] A_SCRATCH = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t          state, state_n;
    logic [DW-1:0]   frame_q, clk_div_q, scratch_q, rd_mux, rdata_q;
    logic            drop_q, busy;
    logic            aw_rdy_q, ar_rdy_q, bvalid_q, rvalid_q;
    logic            wr_en, rd_en, start, drop_set, drop_clr;
    logic [AW-1:0]   wa, ra;
    logic [1:0]      wr_idx, rd_idx;
    logic [7:0]      div_lat, div_cnt;
    logic [5:0]      hcnt;
    logic [4:0]      bit_cnt;
    logic            tick;
    logic            unused_addr_lsbs;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] d,
                                            input logic [DW/8-1:0] s);
        merge = old;
        for (int b = 0; b < DW/8; b++)
            if (s[b]) merge[b*8 +: 8] = d[b*8 +: 8];
    endfunction

    assign wa     = s_axi.S_AXI_AWADDR;
    assign ra     = s_axi.S_AXI_ARADDR;
    assign wr_idx = wa[3:2];
    assign rd_idx = ra[3:2];
    assign unused_addr_lsbs = ^{wa[1:0], ra[1:0]};

    // ready pulses are registered, so a handshake is simply ready & valid
    assign wr_en = aw_rdy_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    assign rd_en = ar_rdy_q & s_axi.S_AXI_ARVALID;
    assign busy  = (state != S_IDLE);

    assign start    = wr_en && wr_idx == A_FRAME && !busy && (|s_axi.S_AXI_WSTRB);
    assign drop_set = wr_en && wr_idx == A_FRAME && busy;
    assign drop_clr = wr_en && wr_idx == A_STATUS && s_axi.S_AXI_WSTRB[0] && s_axi.S_AXI_WDATA[1];

    assign s_axi.S_AXI_AWREADY = aw_rdy_q;
    assign s_axi.S_AXI_WREADY  = aw_rdy_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = ar_rdy_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = 2'b00;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_rdy_q <= 1'b0;
            bvalid_q <= 1'b0;
            ar_rdy_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            aw_rdy_q <= ~aw_rdy_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q;
            if (wr_en)                           bvalid_q <= 1'b1;
            else if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_q <= 1'b0;
            ar_rdy_q <= ~ar_rdy_q & s_axi.S_AXI_ARVALID & ~rvalid_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // read mux sees pre-write register values when read and write share an edge
    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            A_FRAME:   rd_mux = frame_q;
            A_CLK_DIV: rd_mux = clk_div_q;
            A_STATUS:  rd_mux = {{(DW-2){1'b0}}, drop_q, busy};
            A_SCRATCH: rd_mux = scratch_q;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            frame_q   <= '0;
            clk_div_q <= CLK_DIV_RST;
            scratch_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_idx)
                    A_FRAME:   if (!busy) frame_q <= merge(frame_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
                    A_CLK_DIV: clk_div_q <= merge(clk_div_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
                    A_SCRATCH: scratch_q <= merge(scratch_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
                    default: ;
                endcase
            end
            if (drop_set)      drop_q <= 1'b1;
            else if (drop_clr) drop_q <= 1'b0;
        end
    end

    assign tick = (div_cnt == div_lat);

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start)                 state_n = S_SETUP;
            S_SETUP: if (tick)                  state_n = S_SHIFT;
            S_SHIFT: if (tick && hcnt == 6'd63) state_n = S_HOLD;
            S_HOLD:  if (tick)                  state_n = S_GAP;
            S_GAP:   if (tick && hcnt == 6'd1)  state_n = S_IDLE;
            default:                            state_n = S_IDLE;
        endcase
    end

    // hcnt counts half periods within a state; bit_cnt steps on each rising SCLK but the last
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            div_lat <= '0;
            div_cnt <= '0;
            hcnt    <= '0;
            bit_cnt <= 5'd31;
        end else if (state == S_IDLE) begin
            div_cnt <= '0;
            hcnt    <= '0;
            bit_cnt <= 5'd31;
            if (start) div_lat <= clk_div_q[7:0];
        end else if (tick) begin
            div_cnt <= '0;
            hcnt    <= (state_n != state) ? 6'd0 : hcnt + 6'd1;
            if (state == S_SHIFT && !hcnt[0] && bit_cnt != 5'd0)
                bit_cnt <= bit_cnt - 5'd1;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    always_comb begin
        DAC_SYNC_N = 1'b1;
        DAC_SCLK   = 1'b1;
        DAC_DIN    = 1'b0;
        case (state)
            S_SETUP, S_HOLD: begin
                DAC_SYNC_N = 1'b0;
                DAC_DIN    = frame_q[bit_cnt];
            end
            S_SHIFT: begin
                DAC_SYNC_N = 1'b0;
                DAC_SCLK   = hcnt[0];
                DAC_DIN    = frame_q[bit_cnt];
            end
            default: ;
        endcase
    end
endmodule
